seven_seg_scanner: RTL and testbench

Time-multiplexed four-digit seven-segment driver sitting directly downstream of the `Time` block. Consumes its 16-bit BCD HH:MM word and PM flag and scans one digit at a time onto a common-anode display, driving anodes, segments and decimal point. It applies leading-zero suppression, the PM indicator, a blinking colon, and per-digit blink for time-set mode. Runs in the 5 MHz domain and uses the shared 1 Hz pulse for blink phase.

---
 rtl/seven_seg_scanner.sv | 109 ++++++++++
 tb/tb_seven_seg_scanner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode seven-segment scanner for the HH:MM clock display.
// Scans one digit per slot with an anti-ghosting blank window, colon/PM on DP, and per-digit blink.
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 5000,
    parameter int BLANK_CYCLES = 8,
    parameter bit LZ_SUPPRESS  = 1'b1
) (
    input  logic        i_Clk_5MHz,
    input  logic        i_Reset_n,
    input  logic [15:0] i_Time,
    input  logic        i_PM,
    input  logic        i_Clk_1Hz_Pulse,
    input  logic [3:0]  i_Blink_Mask,
    output logic [3:0]  o_Anode,
    output logic [6:0]  o_Segments,
    output logic        o_DP
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      time_q;
    logic             pm_q;
    logic [3:0]       mask_q;
    logic             pulse_q;
    logic             phase_q, phase_d;
    logic [3:0]       anode_q, anode_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             snap_en;
    logic [3:0]       nibble;
    logic             blank;

    always_comb begin
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        idx_d   = (cnt_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
        snap_en = (cnt_q == '0) && (idx_q == 2'd0);
        phase_d = phase_q ^ (i_Clk_1Hz_Pulse & ~pulse_q);

        case (idx_q)
            2'd0:    nibble = time_q[3:0];
            2'd1:    nibble = time_q[7:4];
            2'd2:    nibble = time_q[11:8];
            default: nibble = time_q[15:12];
        endcase

        // Blanking only affects segments; DP keeps carrying PM and colon.
        blank = ((idx_q == 2'd3) && LZ_SUPPRESS && (nibble == 4'd0)) ||
                (mask_q[idx_q] && phase_q);
        seg_d = blank ? 7'b1111111 : seg_decode(nibble);
        dp_d  = ~(((idx_q == 2'd0) && pm_q) || ((idx_q == 2'd2) && !phase_q));

        anode_d = (cnt_q < CNT_BLANK) ? 4'b1111 : ~(4'b0001 << idx_q);
    end

    always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            time_q  <= 16'h0000;
            pm_q    <= 1'b0;
            mask_q  <= 4'b0000;
            pulse_q <= 1'b0;
            phase_q <= 1'b0;
            anode_q <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pulse_q <= i_Clk_1Hz_Pulse;
            phase_q <= phase_d;
            if (snap_en) begin
                time_q <= i_Time;
                pm_q   <= i_PM;
                mask_q <= i_Blink_Mask;
            end
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign o_Anode    = anode_q;
    assign o_Segments = seg_q;
    assign o_DP       = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: per-slot expectations queued by stimulus, checked at each slot start/end.
module tb_seven_seg_scanner;

    localparam int RD = 16;
    localparam int BC = 2;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000, S9 = 7'b0010000;
    localparam logic [6:0] SDASH = 7'b0111111, SBLK = 7'b1111111;

    typedef struct {
        int         start;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] time_in;
    logic        pm;
    logic        pulse;
    logic [3:0]  mask;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;

    int   cyc;
    int   n_checks = 0;
    int   n_fail = 0;
    int   onehot_err = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_SUPPRESS(1'b1)) dut_a (
        .i_Clk_5MHz(clk), .i_Reset_n(rst_n), .i_Time(time_in), .i_PM(pm),
        .i_Clk_1Hz_Pulse(pulse), .i_Blink_Mask(mask),
        .o_Anode(an_a), .o_Segments(seg_a), .o_DP(dp_a)
    );

    seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_SUPPRESS(1'b0)) dut_b (
        .i_Clk_5MHz(clk), .i_Reset_n(rst_n), .i_Time(time_in), .i_PM(pm),
        .i_Clk_1Hz_Pulse(pulse), .i_Blink_Mask(mask),
        .o_Anode(an_b), .o_Segments(seg_b), .o_DP(dp_b)
    );

    // Edge count since reset release: after edge n, cyc == n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic push_frame(input int which, input int base,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic dp0, input logic dp2);
        exp_t e;
        logic [6:0] segs [4];
        logic       dps  [4];
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        dps[0] = dp0; dps[1] = 1'b1; dps[2] = dp2; dps[3] = 1'b1;
        for (int d = 0; d < 4; d++) begin
            e.start = base + d * RD + BC + 1;
            e.an    = ~(4'b0001 << d);
            e.seg   = segs[d];
            e.dp    = dps[d];
            if (which == 0) qa.push_back(e);
            else            qb.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_reset_out(input string nm, input logic [3:0] an,
                                   input logic [6:0] seg, input logic dp);
        n_checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1", nm, an, seg, dp);
        end
    endtask

    // Monitor for instance A
    exp_t       ea;
    logic [3:0] prev_a = 4'hF;
    bit         cur_a_valid = 0;
    int         cur_a_start;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_a = 4'hF;
            cur_a_valid = 0;
        end else begin
            if (prev_a == 4'hF && an_a != 4'hF) begin
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    n_checks++;
                    if (an_a !== ea.an || seg_a !== ea.seg || dp_a !== ea.dp || cyc != ea.start) begin
                        n_fail++;
                        $display("FAIL slotA@%0d: got an=%b seg=%b dp=%b edge=%0d, want an=%b seg=%b dp=%b edge=%0d",
                                 ea.start, an_a, seg_a, dp_a, cyc, ea.an, ea.seg, ea.dp, ea.start);
                    end
                    cur_a_start = ea.start;
                    cur_a_valid = 1;
                end
            end else if (prev_a != 4'hF && an_a == 4'hF && cur_a_valid) begin
                n_checks++;
                if (cyc != cur_a_start + RD - BC) begin
                    n_fail++;
                    $display("FAIL slotA_end@%0d: anodes off at edge %0d, want %0d",
                             cur_a_start, cyc, cur_a_start + RD - BC);
                end
                cur_a_valid = 0;
            end
            if ($countones(~an_a) > 1) onehot_err++;
            prev_a = an_a;
        end
    end

    // Monitor for instance B
    exp_t       eb;
    logic [3:0] prev_b = 4'hF;
    bit         cur_b_valid = 0;
    int         cur_b_start;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_b = 4'hF;
            cur_b_valid = 0;
        end else begin
            if (prev_b == 4'hF && an_b != 4'hF) begin
                if (qb.size() > 0) begin
                    eb = qb.pop_front();
                    n_checks++;
                    if (an_b !== eb.an || seg_b !== eb.seg || dp_b !== eb.dp || cyc != eb.start) begin
                        n_fail++;
                        $display("FAIL slotB@%0d: got an=%b seg=%b dp=%b edge=%0d, want an=%b seg=%b dp=%b edge=%0d",
                                 eb.start, an_b, seg_b, dp_b, cyc, eb.an, eb.seg, eb.dp, eb.start);
                    end
                    cur_b_start = eb.start;
                    cur_b_valid = 1;
                end
            end else if (prev_b != 4'hF && an_b == 4'hF && cur_b_valid) begin
                n_checks++;
                if (cyc != cur_b_start + RD - BC) begin
                    n_fail++;
                    $display("FAIL slotB_end@%0d: anodes off at edge %0d, want %0d",
                             cur_b_start, cyc, cur_b_start + RD - BC);
                end
                cur_b_valid = 0;
            end
            if ($countones(~an_b) > 1) onehot_err++;
            prev_b = an_b;
        end
    end

    initial begin
        rst_n   = 1'b1;
        time_in = 16'h1245;
        pm      = 1'b0;
        pulse   = 1'b0;
        mask    = 4'b0000;
        #1 rst_n = 1'b0;
        #1;
        check_reset_out("resetA", an_a, seg_a, dp_a);
        check_reset_out("resetB", an_b, seg_b, dp_b);
        #10 rst_n = 1'b1;

        // Frame 0: 12:45, colon on
        wait_cyc(1);
        push_frame(0, 0, S5, S4, S2, S1, 1'b1, 1'b0);
        // Mid-frame change must not tear frame 0
        wait_cyc(30);
        time_in = 16'h0907;
        pm      = 1'b1;
        wait_cyc(65);
        push_frame(0, 64, S7, S0, S9, SBLK, 1'b0, 1'b0);
        push_frame(1, 64, S7, S0, S9, S0,   1'b0, 1'b0);
        wait_cyc(100);
        time_in = 16'h23A4;
        pm      = 1'b0;
        wait_cyc(129);
        push_frame(0, 128, S4, SDASH, S3, S2, 1'b1, 1'b0);
        wait_cyc(160);
        time_in = 16'h1034;
        mask    = 4'b0011;
        // 3-cycle pulse: exactly one toggle, phase -> 1
        wait_cyc(180);
        pulse = 1'b1;
        wait_cyc(183);
        pulse = 1'b0;
        wait_cyc(193);
        push_frame(0, 192, SBLK, SBLK, S0, S1, 1'b1, 1'b1);
        // 4-cycle pulse: exactly one toggle, phase -> 0
        wait_cyc(240);
        pulse = 1'b1;
        wait_cyc(244);
        pulse = 1'b0;
        wait_cyc(257);
        push_frame(0, 256, S4, S3, S0, S1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a slot
        wait_cyc(330);
        #2 rst_n = 1'b0;
        #1;
        check_reset_out("midresetA", an_a, seg_a, dp_a);
        check_reset_out("midresetB", an_b, seg_b, dp_b);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(1);
        push_frame(0, 0, S4, S3, S0, S1, 1'b1, 1'b0);
        wait_cyc(70);

        n_checks++;
        if (qa.size() != 0) begin
            n_fail++;
            $display("FAIL queueA_drained: %0d expected slots never shown, want 0", qa.size());
        end
        n_checks++;
        if (qb.size() != 0) begin
            n_fail++;
            $display("FAIL queueB_drained: %0d expected slots never shown, want 0", qb.size());
        end
        n_checks++;
        if (onehot_err != 0) begin
            n_fail++;
            $display("FAIL one_anode: %0d cycles with several anodes low, want 0", onehot_err);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
